// File: rtl/neuron_seq.sv
// Operand-fetch sequencer for one neuron dot product: issues N tagged beats, then captures the final accumulator sum.
// Optional bias beat enabled by defining NEURON_SEQ_BIAS_EN.
module neuron_seq #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    input  logic [CNT_WIDTH-1:0]  num_in_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
`ifdef NEURON_SEQ_BIAS_EN
    input  logic [ADDR_WIDTH-1:0] bias_addr_i,
    output logic                  bias_sel_o,
`endif
    input  logic                  src_rdy_i,
    output logic                  rd_en_o,
    output logic [ADDR_WIDTH-1:0] rd_addr_o,
    output logic                  acc_clr_o,
    output logic                  last_o,
    input  logic                  ac_rdy_i,
    input  logic                  off_i,
    input  logic [DATA_WIDTH-1:0] ac_out_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] result_o
);

    // state | meaning
    // IDLE  | waiting for start
    // ISSUE | one beat offered per cycle, idx advances on src_rdy
    // DRAIN | all beats accepted, waiting for ac_rdy && off
    // DONE  | one-cycle done pulse, result valid
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [CNT_WIDTH-1:0]  idx_q, idx_d;
    logic [CNT_WIDTH-1:0]  n_q, n_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;

    logic                  is_issue;
    logic                  beat_acc;
    logic                  bias_beat;
    logic                  idx_last;
    logic [CNT_WIDTH-1:0]  n_m1;

`ifdef NEURON_SEQ_BIAS_EN
    logic                  bias_q, bias_d;
    logic [ADDR_WIDTH-1:0] bias_addr_q, bias_addr_d;

    assign bias_beat  = is_issue && bias_q;
    assign bias_sel_o = bias_beat;
`else
    assign bias_beat  = 1'b0;
`endif

    assign is_issue = (state_q == S_ISSUE);
    assign beat_acc = is_issue && src_rdy_i;
    assign n_m1     = n_q - CNT_WIDTH'(1);
    assign idx_last = (idx_q == n_m1);

    assign rd_en_o  = is_issue;
    assign busy_o   = (state_q != S_IDLE);
    assign done_o   = (state_q == S_DONE);
    assign result_o = result_q;

    always_comb begin
        rd_addr_o = '0;
        acc_clr_o = 1'b0;
        last_o    = 1'b0;
        if (is_issue) begin
`ifdef NEURON_SEQ_BIAS_EN
            rd_addr_o = bias_beat ? bias_addr_q : base_q + ADDR_WIDTH'(idx_q);
            acc_clr_o = bias_beat;
            last_o    = bias_beat ? (n_q == '0) : idx_last;
`else
            rd_addr_o = base_q + ADDR_WIDTH'(idx_q);
            acc_clr_o = (idx_q == '0);
            last_o    = idx_last;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        n_d      = n_q;
        base_d   = base_q;
        result_d = result_q;
`ifdef NEURON_SEQ_BIAS_EN
        bias_d      = bias_q;
        bias_addr_d = bias_addr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    n_d    = num_in_i;
                    base_d = base_addr_i;
                    idx_d  = '0;
`ifdef NEURON_SEQ_BIAS_EN
                    // the bias beat is always issued, even for an empty neuron
                    bias_d      = 1'b1;
                    bias_addr_d = bias_addr_i;
                    state_d     = S_ISSUE;
`else
                    if (num_in_i == '0) begin
                        result_d = '0;
                        state_d  = S_DONE;
                    end else begin
                        state_d  = S_ISSUE;
                    end
`endif
                end
            end
            S_ISSUE: begin
                if (beat_acc) begin
                    if (bias_beat) begin
`ifdef NEURON_SEQ_BIAS_EN
                        bias_d = 1'b0;
`endif
                        if (n_q == '0) state_d = S_DRAIN;
                    end else begin
                        idx_d = idx_q + CNT_WIDTH'(1);
                        if (idx_last) state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (ac_rdy_i && off_i) begin
                    result_d = ac_out_i;
                    state_d  = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            n_q      <= '0;
            base_q   <= '0;
            result_q <= '0;
`ifdef NEURON_SEQ_BIAS_EN
            bias_q      <= 1'b0;
            bias_addr_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            n_q      <= n_d;
            base_q   <= base_d;
            result_q <= result_d;
`ifdef NEURON_SEQ_BIAS_EN
            bias_q      <= bias_d;
            bias_addr_q <= bias_addr_d;
`endif
        end
    end

endmodule

// File: tb/tb_neuron_seq.sv
// Directed bench for neuron_seq: one table-driven run plus hand-written stall, wrap, reset and empty-neuron sequences.
module tb_neuron_seq;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        start_i;
    logic [7:0]  num_in_i;
    logic [9:0]  base_addr_i;
    logic        src_rdy_i;
    logic        rd_en_o;
    logic [9:0]  rd_addr_o;
    logic        acc_clr_o;
    logic        last_o;
    logic        ac_rdy_i;
    logic        off_i;
    logic [31:0] ac_out_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] result_o;

    int checks   = 0;
    int failures = 0;

    logic [9:0] addr_log [0:15];
    int         acc_cnt;
    int         last_cnt;

    always #5 clk_i = ~clk_i;

    neuron_seq #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .CNT_WIDTH(8)) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .start_i     (start_i),
        .num_in_i    (num_in_i),
        .base_addr_i (base_addr_i),
        .src_rdy_i   (src_rdy_i),
        .rd_en_o     (rd_en_o),
        .rd_addr_o   (rd_addr_o),
        .acc_clr_o   (acc_clr_o),
        .last_o      (last_o),
        .ac_rdy_i    (ac_rdy_i),
        .off_i       (off_i),
        .ac_out_i    (ac_out_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .result_o    (result_o)
    );

    typedef struct packed {
        logic        start;
        logic [7:0]  num;
        logic [9:0]  base;
        logic        src;
        logic        acr;
        logic        off;
        logic [31:0] aco;
        logic        e_rden;
        logic [9:0]  e_addr;
        logic        e_clr;
        logic        e_last;
        logic        e_busy;
        logic        e_done;
        logic [31:0] e_res;
    } vec_t;

    vec_t vecs [0:9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(negedge clk_i);
    endtask

    task automatic idle_inputs();
        start_i     = 1'b0;
        num_in_i    = 8'd0;
        base_addr_i = 10'd0;
        src_rdy_i   = 1'b0;
        ac_rdy_i    = 1'b0;
        off_i       = 1'b0;
        ac_out_i    = 32'd0;
    endtask

    // start a run, then walk the beats with a per-cycle stall mask and a reference index
    task automatic run_beats(input int n, input logic [9:0] base, input logic [15:0] stall, input logic stale);
        int idx;
        int c;
        logic [9:0] ea;
        cyc();
        start_i     = 1'b1;
        num_in_i    = 8'(n);
        base_addr_i = base;
        idx = 0;
        c = 0;
        last_cnt = 0;
        while (idx < n && c < 40) begin
            cyc();
            start_i   = 1'b0;
            src_rdy_i = ~stall[c % 16];
            ac_rdy_i  = stale;
            off_i     = stale;
            ac_out_i  = 32'hDEAD_BEEF;
            #2;
            ea = base + 10'(idx);
            chk("beat_rd_en", {31'd0, rd_en_o}, 32'd1);
            chk("beat_addr", {22'd0, rd_addr_o}, {22'd0, ea});
            chk("beat_acc_clr", {31'd0, acc_clr_o}, (idx == 0) ? 32'd1 : 32'd0);
            chk("beat_last", {31'd0, last_o}, (idx == n - 1) ? 32'd1 : 32'd0);
            if (src_rdy_i) begin
                addr_log[idx] = rd_addr_o;
                if (last_o) last_cnt++;
                idx++;
            end
            c++;
        end
        if (idx < n) chk("beat_timeout", 32'(idx), 32'(n));
        acc_cnt = idx;
        cyc();
        src_rdy_i = 1'b0;
        ac_rdy_i  = 1'b0;
        off_i     = 1'b0;
        #2;
        chk("drain_rd_en", {31'd0, rd_en_o}, 32'd0);
        chk("drain_busy", {31'd0, busy_o}, 32'd1);
    endtask

    task automatic drain(input logic [31:0] value);
        cyc();
        ac_rdy_i = 1'b1;
        off_i    = 1'b0;
        ac_out_i = ~value;
        #2;
        chk("drain_wait_done", {31'd0, done_o}, 32'd0);
        cyc();
        ac_rdy_i = 1'b1;
        off_i    = 1'b1;
        ac_out_i = value;
        cyc();
        ac_rdy_i = 1'b0;
        off_i    = 1'b0;
        ac_out_i = 32'd0;
        #2;
        chk("done_pulse", {31'd0, done_o}, 32'd1);
        chk("done_result", result_o, value);
        cyc();
        #2;
        chk("done_once", {31'd0, done_o}, 32'd0);
        chk("idle_busy", {31'd0, busy_o}, 32'd0);
        chk("result_hold", result_o, value);
    endtask

    initial begin
        int dcnt;
        int first_done;

        //          start num  base    src  acr  off  aco            rden addr    clr last busy done res
        vecs[0] = '{1'b1, 8'd4, 10'h010, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[1] = '{1'b0, 8'd0, 10'h000, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 10'h010, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0};
        vecs[2] = '{1'b1, 8'd9, 10'h200, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 10'h011, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
        vecs[3] = '{1'b0, 8'd0, 10'h000, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 10'h012, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
        vecs[4] = '{1'b0, 8'd0, 10'h000, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 10'h013, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0};
        vecs[5] = '{1'b0, 8'd0, 10'h000, 1'b0, 1'b1, 1'b0, 32'h5555_5555, 1'b0, 10'h000, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
        vecs[6] = '{1'b0, 8'd0, 10'h000, 1'b0, 1'b1, 1'b1, 32'h0000_1234, 1'b0, 10'h000, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
        vecs[7] = '{1'b1, 8'd2, 10'h300, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 10'h000, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_1234};
        vecs[8] = '{1'b0, 8'd0, 10'h000, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_1234};
        vecs[9] = '{1'b0, 8'd0, 10'h000, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_1234};

        idle_inputs();
        reset_i = 1'b1;
        start_i = 1'b1;
        num_in_i = 8'd3;
        cyc();
        cyc();
        #2;
        chk("rst_rd_en", {31'd0, rd_en_o}, 32'd0);
        chk("rst_addr", {22'd0, rd_addr_o}, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_done", {31'd0, done_o}, 32'd0);
        chk("rst_result", result_o, 32'd0);
        idle_inputs();
        reset_i = 1'b0;

        // num_in=4 at 0x010, a start while busy, a non-final ac_rdy and a start in DONE
        for (int i = 0; i < 10; i++) begin
            cyc();
            start_i     = vecs[i].start;
            num_in_i    = vecs[i].num;
            base_addr_i = vecs[i].base;
            src_rdy_i   = vecs[i].src;
            ac_rdy_i    = vecs[i].acr;
            off_i       = vecs[i].off;
            ac_out_i    = vecs[i].aco;
            #2;
            chk($sformatf("vec%0d_rd_en", i), {31'd0, rd_en_o}, {31'd0, vecs[i].e_rden});
            chk($sformatf("vec%0d_addr", i), {22'd0, rd_addr_o}, {22'd0, vecs[i].e_addr});
            chk($sformatf("vec%0d_acc_clr", i), {31'd0, acc_clr_o}, {31'd0, vecs[i].e_clr});
            chk($sformatf("vec%0d_last", i), {31'd0, last_o}, {31'd0, vecs[i].e_last});
            chk($sformatf("vec%0d_busy", i), {31'd0, busy_o}, {31'd0, vecs[i].e_busy});
            chk($sformatf("vec%0d_done", i), {31'd0, done_o}, {31'd0, vecs[i].e_done});
            chk($sformatf("vec%0d_result", i), result_o, vecs[i].e_res);
        end
        idle_inputs();

        // stall on the second and third ISSUE cycles: 0x001 held for three cycles
        run_beats(3, 10'h000, 16'b0000_0000_0000_0110, 1'b0);
        chk("stall_accepts", 32'(acc_cnt), 32'd3);
        chk("stall_last_cnt", 32'(last_cnt), 32'd1);
        chk("stall_addr1", {22'd0, addr_log[1]}, 32'h001);
        chk("stall_addr2", {22'd0, addr_log[2]}, 32'h002);
        drain(32'hCAFE_0001);

        // address wrap, with a stale final-sum strobe during ISSUE that must be ignored
        run_beats(3, 10'h3FE, 16'h0000, 1'b1);
        chk("wrap_addr0", {22'd0, addr_log[0]}, 32'h3FE);
        chk("wrap_addr1", {22'd0, addr_log[1]}, 32'h3FF);
        chk("wrap_addr2", {22'd0, addr_log[2]}, 32'h000);
        drain(32'h0BEE_F000);

        // reset in the middle of ISSUE abandons the run
        cyc();
        start_i     = 1'b1;
        num_in_i    = 8'd5;
        base_addr_i = 10'h100;
        cyc();
        start_i   = 1'b0;
        src_rdy_i = 1'b1;
        cyc();
        cyc();
        reset_i = 1'b1;
        cyc();
        reset_i = 1'b0;
        #2;
        chk("midrst_rd_en", {31'd0, rd_en_o}, 32'd0);
        chk("midrst_addr", {22'd0, rd_addr_o}, 32'd0);
        chk("midrst_busy", {31'd0, busy_o}, 32'd0);
        chk("midrst_result", result_o, 32'd0);
        dcnt = 0;
        for (int c = 0; c < 4; c++) begin
            cyc();
            #2;
            if (done_o || busy_o) dcnt++;
        end
        chk("midrst_no_done", 32'(dcnt), 32'd0);
        idle_inputs();

        run_beats(2, 10'h020, 16'h0000, 1'b0);
        chk("rerun_accepts", 32'(acc_cnt), 32'd2);
        chk("rerun_addr1", {22'd0, addr_log[1]}, 32'h021);
        drain(32'h7777_0002);

        // empty neuron: straight to DONE with a zero result and no beats
        cyc();
        start_i     = 1'b1;
        num_in_i    = 8'd0;
        base_addr_i = 10'h055;
        src_rdy_i   = 1'b1;
        dcnt = 0;
        first_done = -1;
        for (int c = 0; c < 4; c++) begin
            cyc();
            start_i = 1'b0;
            #2;
            chk("zero_rd_en", {31'd0, rd_en_o}, 32'd0);
            if (done_o) begin
                dcnt++;
                if (first_done < 0) begin
                    first_done = c;
                    chk("zero_result", result_o, 32'd0);
                end
            end
        end
        chk("zero_done_cnt", 32'(dcnt), 32'd1);
        chk("zero_done_cycle", 32'(first_done), 32'd0);
        idle_inputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
